// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB bridge: one APB transfer per accepted AHB NONSEQ/SEQ transfer.
// Optional build macro AHB2APB_PREADY_EN: when defined, PREADY/PSLVERR are honoured
// (APB wait states and error responses); otherwise every ACCESS lasts one cycle
// and the error states are never entered.

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb2apb_bridge #(
  parameter int unsigned PADDR_W = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [`AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [`AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic [1:0]                 HRESP,
  output logic [`AHB_DATA_WIDTH-1:0] HRDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [PADDR_W-1:0]         PADDR,
  output logic [`AHB_DATA_WIDTH-1:0] PWDATA,
  input  logic [`AHB_DATA_WIDTH-1:0] PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int unsigned DW = `AHB_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PADDR_W-1:0]   paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DW-1:0]        pwdata_q, pwdata_d;

  logic                 pready_c;
  logic                 pslverr_c;
  logic                 done_c;
  logic                 accept_c;

`ifdef AHB2APB_PREADY_EN
  assign pready_c  = PREADY;
  assign pslverr_c = PSLVERR;
  logic unused_ok;
  assign unused_ok = &{1'b0, HSIZE, HTRANS[0], HADDR};
`else
  // APB completion is implied; the handshake ports stay on the boundary but are ignored
  assign pready_c  = 1'b1;
  assign pslverr_c = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, HSIZE, HTRANS[0], HADDR, PREADY, PSLVERR};
`endif

  // Successful ACCESS completion, and acceptance of a new AHB transfer
  always_comb begin
    done_c   = (state_q == ST_ACCESS) & pready_c & ~pslverr_c;
    accept_c = HSEL & HTRANS[1] & HREADY &
               ((state_q == ST_IDLE) | done_c | (state_q == ST_ERR2));
  end

  // Bridge state and APB address/control/write-data holding registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  // Next-state logic; address/control captured on accept, write data at end of SETUP
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    if (accept_c) begin
      paddr_d  = HADDR[PADDR_W-1:0];
      pwrite_d = HWRITE;
    end
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_SETUP;
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        pwdata_d = HWDATA;
      end
      ST_ACCESS: begin
        if (pready_c) begin
          if (pslverr_c)     state_d = ST_ERR1;
          else if (accept_c) state_d = ST_SETUP;
          else               state_d = ST_IDLE;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = accept_c ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state APB strobes and AHB response; HRDATA/HREADYOUT pass through in ACCESS
  always_comb begin
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = '0;
    PWDATA    = pwdata_q;
    case (state_q)
      ST_SETUP: begin
        PSEL      = 1'b1;
        HREADYOUT = 1'b0;
        PWDATA    = HWDATA;
      end
      ST_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYOUT = done_c;
        HRDATA    = PRDATA;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
      end
      ST_ERR2: begin
        HRESP     = 2'b01;
      end
      default: ;
    endcase
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;

endmodule
